// File: rtl/muldiv_ctrl_seq.sv
// muldiv_ctrl_seq: hardwired fetch + MUL/DIV execute sequencer driving the DataPath strobes.
// Define MULDIV_TIMEOUT_EN to add a watchdog that abandons a WAIT longer than WAIT_MAX cycles.
module muldiv_ctrl_seq #(
    parameter logic [4:0] OP_MUL   = 5'b01111,
    parameter logic [4:0] OP_DIV   = 5'b10000,
    parameter logic [3:0] ALU_MUL  = 4'b0010,
    parameter logic [3:0] ALU_DIV  = 4'b0011,
    parameter int         WAIT_MAX = 64
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    input  logic        alu_done,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin_low,
    output logic        Zin_high,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic [15:0] Rout,
    output logic [3:0]  operation,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_WAIT, S_T5, S_T6
    } state_t;

    state_t      state_q, state_d;
    logic        t0_q, t0_d;
    logic        first_t1_q, first_t1_d;
    logic        t1_q, t1_d;
    logic        t2_q, t2_d;
    logic        t5_q, t5_d;
    logic        t6_q, t6_d;
    logic        busy_q, busy_d;
    logic [15:0] rout_b_q, rout_b_d;
    logic [3:0]  op_q, op_d;

    logic [4:0]  opcode;
    logic [15:0] ra_onehot;
    logic [15:0] rb_onehot;
    logic        is_div;
    logic        legal;
    logic        t3_legal;
    logic        unused_ir;

    assign opcode    = ir[31:27];
    assign ra_onehot = 16'h0001 << ir[26:23];
    assign rb_onehot = 16'h0001 << ir[22:19];
    assign is_div    = (opcode == OP_DIV);
    assign legal     = (opcode == OP_MUL) || is_div;
    assign t3_legal  = (state_q == S_T3) && legal;
    assign unused_ir = ^ir[18:0];

`ifdef MULDIV_TIMEOUT_EN
    logic [6:0] wait_cnt_q, wait_cnt_d;
    logic       timeout;
    logic       timeout_ill_q, timeout_ill_d;
`else
    localparam int unused_wait_max = WAIT_MAX;
`endif

    always_comb begin
        state_d = state_q;
`ifdef MULDIV_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            S_IDLE:  if (start) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (mem_rdy) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = legal ? S_T4 : S_IDLE;
            S_T4:    state_d = S_WAIT;
            S_WAIT: begin
                if (alu_done) begin
                    state_d = S_T5;
                end
`ifdef MULDIV_TIMEOUT_EN
                else if (wait_cnt_q == 7'(WAIT_MAX - 1)) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end
`endif
            end
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state; Rb and the ALU op are captured while IR is valid in T3.
    always_comb begin
        t0_d       = (state_d == S_T0);
        first_t1_d = (state_d == S_T1) && (state_q == S_T0);
        t1_d       = (state_d == S_T1);
        t2_d       = (state_d == S_T2);
        t5_d       = (state_d == S_T5);
        t6_d       = (state_d == S_T6);
        busy_d     = (state_d != S_IDLE);
        rout_b_d   = 16'h0000;
        op_d       = 4'b0000;
        if ((state_d == S_T4) || (state_d == S_WAIT)) begin
            if (state_q == S_T3) begin
                rout_b_d = rb_onehot;
                op_d     = is_div ? ALU_DIV : ALU_MUL;
            end else begin
                rout_b_d = rout_b_q;
                op_d     = op_q;
            end
        end
`ifdef MULDIV_TIMEOUT_EN
        wait_cnt_d    = ((state_d == S_WAIT) && (state_q == S_WAIT)) ? wait_cnt_q + 7'd1 : 7'd0;
        timeout_ill_d = timeout;
`endif
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q       <= S_IDLE;
            t0_q          <= 1'b0;
            first_t1_q    <= 1'b0;
            t1_q          <= 1'b0;
            t2_q          <= 1'b0;
            t5_q          <= 1'b0;
            t6_q          <= 1'b0;
            busy_q        <= 1'b0;
            rout_b_q      <= 16'h0000;
            op_q          <= 4'b0000;
`ifdef MULDIV_TIMEOUT_EN
            wait_cnt_q    <= 7'd0;
            timeout_ill_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            t0_q          <= t0_d;
            first_t1_q    <= first_t1_d;
            t1_q          <= t1_d;
            t2_q          <= t2_d;
            t5_q          <= t5_d;
            t6_q          <= t6_d;
            busy_q        <= busy_d;
            rout_b_q      <= rout_b_d;
            op_q          <= op_d;
`ifdef MULDIV_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_ill_q <= timeout_ill_d;
`endif
        end
    end

    assign PCout     = t0_q;
    assign MARin     = t0_q;
    assign IncPC     = t0_q;
    assign PCin      = first_t1_q;
    assign Read      = t1_q;
    assign MDRin     = t1_q;
    assign MDRout    = t2_q;
    assign IRin      = t2_q;
    assign Yin       = t3_legal;
    // The Z latch strobes in WAIT follow alu_done directly so the result is caught in the cycle it appears.
    assign Zin_low   = t0_q | ((state_q == S_WAIT) && alu_done);
    assign Zin_high  = (state_q == S_WAIT) && alu_done;
    assign Zlowout   = first_t1_q | t5_q;
    assign Zhighout  = t6_q;
    assign LOin      = t5_q;
    assign HIin      = t6_q;
    assign Rout      = rout_b_q | (t3_legal ? ra_onehot : 16'h0000);
    assign operation = op_q;
    assign busy      = busy_q;
    assign done      = t6_q;
`ifdef MULDIV_TIMEOUT_EN
    assign illegal   = ((state_q == S_T3) && !legal) | timeout_ill_q;
`else
    assign illegal   = (state_q == S_T3) && !legal;
`endif

endmodule

// File: tb/tb_muldiv_ctrl_seq.sv
// Bench for muldiv_ctrl_seq: a cycle-schedule model built from the sequencing rules drives inputs
// and predicts every output each cycle; literal checks pin latencies, Rout values and pulse counts.
module tb_muldiv_ctrl_seq;

    logic        Clock = 1'b0;
    logic        clear, start, mem_rdy, alu_done;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic        Zin_low, Zin_high, Zlowout, Zhighout, LOin, HIin;
    logic [15:0] Rout;
    logic [3:0]  operation;
    logic        busy, done, illegal;

    muldiv_ctrl_seq dut (
        .Clock(Clock), .clear(clear), .start(start), .ir(ir),
        .mem_rdy(mem_rdy), .alu_done(alu_done),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin_low(Zin_low), .Zin_high(Zin_high), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .LOin(LOin), .HIin(HIin), .Rout(Rout), .operation(operation),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
        logic zin_low, zin_high, zlow_out, zhigh_out, lo_in, hi_in;
        logic [15:0] rout;
        logic [3:0]  op;
        logic        busy, done, illegal;
    } out_vec_t;

    typedef struct {
        logic     start;
        logic     mem_rdy;
        logic     alu_done;
        out_vec_t exp;
        string    tag;
    } step_t;

    step_t       sched[$];
    step_t       cmp_q[$];
    step_t       cur;
    out_vec_t    act;
    int          vec_cnt, miss_cnt;
    int          busy_cnt, pcin_cnt, read_cnt, yin_cnt, loin_cnt, hiin_cnt, ill_cnt;
    logic [15:0] t3_rout, t4_rout;
    logic [3:0]  op_seen;

    assign act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
                  Zin_low, Zin_high, Zlowout, Zhighout, LOin, HIin,
                  Rout, operation, busy, done, illegal};

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_step(input string tag, input logic st, input logic mr, input logic ad, input out_vec_t e);
        step_t s;
        s.start    = st;
        s.mem_rdy  = mr;
        s.alu_done = ad;
        s.exp      = e;
        s.tag      = tag;
        sched.push_back(s);
    endtask

    // alu_wait < 0 means the ALU never answers (watchdog case)
    task automatic build_sched(input string label, input logic [31:0] instr, input int mem_stall,
                               input int alu_wait, input bit mid_start);
        out_vec_t   z, e;
        logic [4:0] opc;
        logic [3:0] ra, rb;
        bit         legal;
        z     = '0;
        opc   = instr[31:27];
        ra    = instr[26:23];
        rb    = instr[22:19];
        legal = (opc == 5'b01111) || (opc == 5'b10000);
        add_step({label, " idle/start"}, 1'b1, 1'b0, 1'b0, z);
        e = z; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zin_low = 1;
        add_step({label, " T0"}, 1'b0, 1'b0, 1'b0, e);
        for (int j = 0; j <= mem_stall; j++) begin
            e = z; e.busy = 1; e.read = 1; e.mdr_in = 1;
            e.pc_in = (j == 0); e.zlow_out = (j == 0);
            add_step({label, " T1"}, mid_start && (j == 0), j == mem_stall, 1'b0, e);
        end
        e = z; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
        add_step({label, " T2"}, 1'b0, 1'b0, 1'b0, e);
        e = z; e.busy = 1;
        if (legal) begin
            e.rout = 16'd1 << ra;
            e.y_in = 1;
        end else begin
            e.illegal = 1;
        end
        add_step({label, " T3"}, 1'b0, 1'b0, 1'b0, e);
        if (legal) begin
            e = z; e.busy = 1; e.rout = 16'd1 << rb;
            e.op = (opc == 5'b10000) ? 4'b0011 : 4'b0010;
            add_step({label, " T4"}, 1'b0, 1'b0, 1'b0, e);
            if (alu_wait >= 0) begin
                for (int j = 0; j <= alu_wait; j++) begin
                    e.zin_low  = (j == alu_wait);
                    e.zin_high = (j == alu_wait);
                    add_step({label, " WAIT"}, 1'b0, 1'b0, j == alu_wait, e);
                end
                e = z; e.busy = 1; e.zlow_out = 1; e.lo_in = 1;
                add_step({label, " T5"}, 1'b0, 1'b0, 1'b0, e);
                e = z; e.busy = 1; e.zhigh_out = 1; e.hi_in = 1; e.done = 1;
                add_step({label, " T6"}, 1'b0, 1'b0, 1'b0, e);
            end else begin
                for (int j = 0; j < 64; j++) begin
                    add_step({label, " WAIT"}, 1'b0, 1'b0, 1'b0, e);
                end
                e = z; e.illegal = 1;
                add_step({label, " timeout"}, 1'b0, 1'b0, 1'b0, e);
            end
        end
        add_step({label, " idle"}, 1'b0, 1'b0, 1'b0, z);
        add_step({label, " idle"}, 1'b0, 1'b0, 1'b0, z);
    endtask

    task automatic applyStimulus(input step_t s);
        start    = s.start;
        mem_rdy  = s.mem_rdy;
        alu_done = s.alu_done;
        cmp_q.push_back(s);
    endtask

    // keep_steps > 0 truncates the schedule so the instruction can be aborted mid-flight
    task automatic run_seq(input string label, input logic [31:0] instr, input int mem_stall,
                           input int alu_wait, input bit mid_start, input int keep_steps);
        step_t s;
        busy_cnt = 0; pcin_cnt = 0; read_cnt = 0; yin_cnt = 0;
        loin_cnt = 0; hiin_cnt = 0; ill_cnt = 0;
        t3_rout = '0; t4_rout = '0; op_seen = '0;
        sched.delete();
        build_sched(label, instr, mem_stall, alu_wait, mid_start);
        if (keep_steps > 0) begin
            while (sched.size() > keep_steps) void'(sched.pop_back());
        end
        ir = instr;
        while (sched.size() > 0) begin
            @(posedge Clock);
            #1;
            s = sched.pop_front();
            applyStimulus(s);
        end
        @(negedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        if (cmp_q.size() > 0) begin
            cur = cmp_q.pop_front();
            checkOutput(cur.tag, 64'(act), 64'(cur.exp));
            if (busy)    busy_cnt++;
            if (PCin)    pcin_cnt++;
            if (Read)    read_cnt++;
            if (Yin)     yin_cnt++;
            if (LOin)    loin_cnt++;
            if (HIin)    hiin_cnt++;
            if (illegal) ill_cnt++;
            if (Yin)     t3_rout = Rout;
            if (operation != 4'd0) begin
                t4_rout = Rout;
                op_seen = operation;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_cnt = 0; miss_cnt = 0;
        clear = 1'b0; start = 1'b0; ir = '0; mem_rdy = 1'b0; alu_done = 1'b0;
        #12;
        checkOutput("reset outputs", 64'(act), 64'd0);
        @(negedge Clock);
        clear = 1'b1;
        repeat (2) @(posedge Clock);

        run_seq("div R6,R7", 32'h83380000, 0, 2, 1'b0, 0);
        checkOutput("div start-to-done cycles", busy_cnt, 10);
        checkOutput("div T3 Rout", t3_rout, 16'h0040);
        checkOutput("div T4 Rout", t4_rout, 16'h0080);
        checkOutput("div operation", op_seen, 4'b0011);
        checkOutput("div LOin pulses", loin_cnt, 1);
        checkOutput("div HIin pulses", hiin_cnt, 1);

        run_seq("mul R6,R7", 32'h7B380000, 0, 0, 1'b0, 0);
        checkOutput("mul start-to-done cycles", busy_cnt, 8);
        checkOutput("mul PCin cycles", pcin_cnt, 1);
        checkOutput("mul operation", op_seen, 4'b0010);

        run_seq("mul mem stall", 32'h7B380000, 4, 1, 1'b0, 0);
        checkOutput("stall Read cycles", read_cnt, 5);
        checkOutput("stall PCin cycles", pcin_cnt, 1);
        checkOutput("stall busy cycles", busy_cnt, 13);

        run_seq("illegal op", 32'h00000000, 0, 0, 1'b1, 0);
        checkOutput("illegal pulses", ill_cnt, 1);
        checkOutput("illegal Yin cycles", yin_cnt, 0);
        checkOutput("illegal LOin/HIin", loin_cnt + hiin_cnt, 0);
        checkOutput("illegal busy cycles", busy_cnt, 4);

        run_seq("mul R15,R15", {5'b01111, 4'd15, 4'd15, 19'd0}, 1, 3, 1'b0, 0);
        checkOutput("Ra=Rb T3 Rout", t3_rout, 16'h8000);
        checkOutput("Ra=Rb T4 Rout", t4_rout, 16'h8000);

        run_seq("div R0,R9", {5'b10000, 4'd0, 4'd9, 19'd0}, 2, 1, 1'b0, 0);
        checkOutput("div R0 T3 Rout", t3_rout, 16'h0001);
        checkOutput("div R9 T4 Rout", t4_rout, 16'h0200);

        run_seq("div abort", 32'h83380000, 0, 100, 1'b0, 8);
        clear = 1'b0;
        #1;
        checkOutput("async clear outputs", 64'(act), 64'd0);
        @(posedge Clock);
        #1;
        checkOutput("held clear outputs", 64'(act), 64'd0);
        #2;
        clear = 1'b1;
        run_seq("mul after clear", 32'h7B380000, 0, 0, 1'b0, 0);
        checkOutput("post-clear start-to-done", busy_cnt, 8);

`ifdef MULDIV_TIMEOUT_EN
        run_seq("mul timeout", 32'h7B380000, 0, -1, 1'b0, 0);
        checkOutput("timeout busy cycles", busy_cnt, 69);
        checkOutput("timeout illegal pulses", ill_cnt, 1);
        checkOutput("timeout LOin/HIin", loin_cnt + hiin_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
